fetch_prefetch_unit: RTL and testbench



---
 rtl/fetch_prefetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch: Avalon read master feeding a small prefetch FIFO.
// Redirect flushes buffered and in-flight words and restarts at a new PC.
module fetch_prefetch_unit #(
  parameter logic [29:0] RESET_PC   = 30'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  output logic [29:0] o_AV_Addr,
  output logic        o_AV_Read,
  input  logic [31:0] i_AV_ReadData,
  input  logic        i_AV_WaitRequest,
  input  logic        i_Redirect,
  input  logic [29:0] i_RedirectAddr,
  output logic [31:0] o_Instr,
  output logic [29:0] o_InstrAddr,
  output logic        o_Valid,
  input  logic        i_Ready
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [29:0] pc;
  logic        inflight;
  logic [29:0] infl_addr;

  logic [31:0] mem_data [FIFO_DEPTH];
  logic [29:0] mem_addr [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW+1:0] used;

  logic [31:0] last_instr;
  logic [29:0] last_addr;

  logic accept;
  logic push;
  logic pop;

  // Credit check counts the word still on the bus so the FIFO never overflows
  assign used = {1'b0, count} + {{(AW + 1){1'b0}}, inflight};

  assign o_AV_Addr = pc;
  assign o_AV_Read = (state == S_RUN) && !i_Redirect
                   && (used < (AW + 2)'(FIFO_DEPTH));

  assign accept = o_AV_Read && !i_AV_WaitRequest;
  assign push   = inflight && (state != S_FLUSH) && !i_Redirect;
  assign o_Valid = (count != '0);
  assign pop    = o_Valid && i_Ready && !i_Redirect;

  assign o_Instr     = o_Valid ? mem_data[rd_ptr] : last_instr;
  assign o_InstrAddr = o_Valid ? mem_addr[rd_ptr] : last_addr;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RESET: state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      S_FLUSH: state_nxt = S_RUN;
      default: state_nxt = S_RESET;
    endcase
    if (i_Redirect) state_nxt = S_FLUSH;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state      <= S_RESET;
      pc         <= RESET_PC;
      inflight   <= 1'b0;
      infl_addr  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_instr <= '0;
      last_addr  <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= accept;
      if (accept) begin
        pc        <= pc + 30'd1;
        infl_addr <= pc;
      end
      if (o_Valid) begin
        last_instr <= mem_data[rd_ptr];
        last_addr  <= mem_addr[rd_ptr];
      end
      if (i_Redirect) begin
        pc     <= i_RedirectAddr;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        unique case ({push, pop})
          2'b10:   count <= count + (AW + 1)'(1);
          2'b01:   count <= count - (AW + 1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: count gates visibility of every entry
  always_ff @(posedge i_Clk) begin
    if (push) begin
      mem_data[wr_ptr] <= i_AV_ReadData;
      mem_addr[wr_ptr] <= infl_addr;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: boot ROM slave model plus a
// scoreboard queue of expected {instr, addr} drained by a monitor.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] av_addr;
  logic        av_read;
  logic [31:0] av_rdata = '0;
  logic        wreq = 1'b0;
  logic        redir = 1'b0;
  logic [29:0] raddr = '0;
  logic [31:0] instr;
  logic [29:0] iaddr;
  logic        valid;
  logic        rdy = 1'b0;

  typedef struct {
    logic [31:0] instr;
    logic [29:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;

  fetch_prefetch_unit #(
    .RESET_PC  (30'h0),
    .FIFO_DEPTH(4)
  ) dut (
    .i_Clk           (clk),
    .i_Rst           (rst),
    .o_AV_Addr       (av_addr),
    .o_AV_Read       (av_read),
    .i_AV_ReadData   (av_rdata),
    .i_AV_WaitRequest(wreq),
    .i_Redirect      (redir),
    .i_RedirectAddr  (raddr),
    .o_Instr         (instr),
    .o_InstrAddr     (iaddr),
    .o_Valid         (valid),
    .i_Ready         (rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [29:0] a);
    case (a)
      30'h0:   rom = 32'hA00000B7;
      30'h1:   rom = 32'h00008023;
      default: rom = {a, 2'b00} ^ 32'hC3C30000;
    endcase
  endfunction

  always @(posedge clk)
    if (av_read && !wreq) av_rdata <= rom(av_addr);

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  always @(negedge clk) begin
    if (!rst && valid && rdy && !redir) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word actual=%0h@%0h required=none",
                 instr, iaddr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("deliver_addr", 64'(iaddr), 64'(e.addr));
        chk("deliver_instr", 64'(instr), 64'(e.instr));
      end
    end
  end

  task automatic push_exp(input logic [29:0] a);
    exp_q.push_back('{rom(a), a});
  endtask

  task automatic do_reset();
    rdy = 0; redir = 0; wreq = 0; raddr = '0; rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    exp_q.delete();
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) done = 1;
    end
    rdy = 0;
    chk(nm, 64'(done), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    // Boot stream: latency and one word per cycle
    do_reset();
    rdy = 1;
    for (int a = 0; a < 8; a++) push_exp(30'(a));
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("rst_read", 64'(av_read), 64'(0));
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_instr", 64'(instr), 64'(0));
        chk("rst_iaddr", 64'(iaddr), 64'(0));
        chk("rst_addr", 64'(av_addr), 64'(0));
      end
      if (c == 1) begin
        chk("t1_read", 64'(av_read), 64'(1));
        chk("t1_addr", 64'(av_addr), 64'(0));
      end
      if (c == 2) chk("t1_valid_c2", 64'(valid), 64'(0));
      if (c >= 3) chk("t1_stream", 64'(valid), 64'(1));
      if (c == 10) begin
        #1 rdy = 0;
      end
      next_cyc();
    end
    chk("t1_drained", 64'(exp_q.size()), 64'(0));

    // Backpressure: FIFO fills with exactly four words
    do_reset();
    acc = 0;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      if (av_read && !wreq) acc++;
      if (c == 9) chk("t2_read_off", 64'(av_read), 64'(0));
      next_cyc();
    end
    chk("t2_accepts", 64'(acc), 64'(4));
    for (int a = 0; a < 8; a++) push_exp(30'(a));
    rdy = 1;
    drain("t2_drain", 40);

    // Waitrequest on address 2 for three cycles
    do_reset();
    rdy = 1;
    for (int a = 0; a < 8; a++) push_exp(30'(a));
    for (int c = 0; c <= 6; c++) begin
      if (c == 3) wreq = 1;
      if (c == 6) wreq = 0;
      @(negedge clk);
      if (c >= 3 && c <= 5) begin
        chk("t3_stall_addr", 64'(av_addr), 64'(2));
        chk("t3_stall_read", 64'(av_read), 64'(1));
      end
      next_cyc();
    end
    drain("t3_drain", 40);

    // Redirect with two buffered words and one in flight
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      if (c == 4) begin
        redir = 1;
        raddr = 30'h10;
      end
      if (c == 5) redir = 0;
      if (c == 8) begin
        rdy = 1;
        push_exp(30'h10);
        push_exp(30'h11);
        push_exp(30'h12);
      end
      @(negedge clk);
      if (c == 4) chk("t4_read_r", 64'(av_read), 64'(0));
      if (c == 5) chk("t4_valid_r1", 64'(valid), 64'(0));
      if (c == 6) begin
        chk("t4_read_r2", 64'(av_read), 64'(1));
        chk("t4_addr_r2", 64'(av_addr), 64'(30'h10));
      end
      if (c == 7) chk("t4_valid_r3", 64'(valid), 64'(0));
      if (c == 8) begin
        chk("t4_valid_r4", 64'(valid), 64'(1));
        chk("t4_iaddr_r4", 64'(iaddr), 64'(30'h10));
      end
      next_cyc();
    end
    drain("t4_drain", 40);

    // Redirect and pop in the same cycle
    do_reset();
    rdy = 1;
    push_exp(30'h0);
    push_exp(30'h20);
    push_exp(30'h21);
    push_exp(30'h22);
    for (int c = 0; c <= 4; c++) begin
      if (c == 4) begin
        redir = 1;
        raddr = 30'h20;
      end
      @(negedge clk);
      if (c == 4) chk("t5_valid_r", 64'(valid), 64'(1));
      next_cyc();
    end
    redir = 0;
    drain("t5_drain", 40);

    // PC wrap, redirect taken while still in reset state
    do_reset();
    redir = 1;
    raddr = 30'h3FFFFFFF;
    next_cyc();
    redir = 0;
    rdy = 1;
    push_exp(30'h3FFFFFFF);
    push_exp(30'h0);
    push_exp(30'h1);
    next_cyc();
    @(negedge clk);
    chk("t6_read", 64'(av_read), 64'(1));
    chk("t6_addr", 64'(av_addr), 64'(30'h3FFFFFFF));
    drain("t6_drain", 40);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
